// File: rtl/serial_adder_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | serial_adder_pkg : shared FSM encoding and limits for serial_adder_ctrl |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
package serial_adder_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_adder_ctrl_single_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | SingleStage : one-bit full-adder cell shared by the serial controller  |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
module SingleStage (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | serial_adder_ctrl : bit-serial add/subtract over one full-adder cell   |
// | Rev 1.0                                                                 |
// +-----------------------------------------------------------------------+
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_sum_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             w_cell_s;
  logic             w_cell_cout;
  logic             w_accept;
  logic             w_last;

  SingleStage u_cell (
    .i_a    (r_a_sr[0]),
    .i_b    (r_b_sr[0]),
    .i_cin  (r_carry),
    .o_s    (w_cell_s),
    .o_cout (w_cell_cout)
  );

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next_state = SHIFT;
      SHIFT:   if (w_last) w_next_state = DONE;
      DONE:    w_next_state = start ? SHIFT : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // New result bit enters at the MSB; after WIDTH shifts the LSB sits at bit 0.
  always_comb begin
    w_sum_next             = r_sum >> 1;
    w_sum_next[WIDTH-1]    = w_cell_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_sr  <= a;
      r_b_sr  <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : cin;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_a_sr  <= r_a_sr >> 1;
      r_b_sr  <= r_b_sr >> 1;
      r_sum   <= w_sum_next;
      r_carry <= w_cell_cout;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        // r_carry is the carry into the MSB at this point.
        r_cout <= w_cell_cout;
        r_ovf  <= r_carry ^ w_cell_cout;
      end
    end
  end

  assign busy     = (r_state == SHIFT);
  assign done     = (r_state == DONE);
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// tb_serial_adder_ctrl : directed vectors with a queue scoreboard per DUT width.
module tb_serial_adder_ctrl;

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ov;
    int         due;
  } exp_t;

  logic       clk;
  logic       rst;
  int         cyc;
  int         n_tests;
  int         n_fail;

  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start1, sub1, cin1;
  logic [0:0] a1, b1;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;

  exp_t q8[$];
  exp_t q1[$];
  exp_t e8, e1;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) begin
        chk("done8_unexpected", {63'd0, done8}, 64'd0);
      end else begin
        e8 = q8.pop_front();
        chk("sum8", {56'd0, sum8}, {56'd0, e8.s});
        chk("cout8", {63'd0, cout8}, {63'd0, e8.co});
        chk("ovf8", {63'd0, ovf8}, {63'd0, e8.ov});
        chk("latency8", 64'(cyc), 64'(e8.due));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done1) begin
      if (q1.size() == 0) begin
        chk("done1_unexpected", {63'd0, done1}, 64'd0);
      end else begin
        e1 = q1.pop_front();
        chk("sum1", {63'd0, sum1}, {63'd0, e1.s[0]});
        chk("cout1", {63'd0, cout1}, {63'd0, e1.co});
        chk("ovf1", {63'd0, ovf1}, {63'd0, e1.ov});
        chk("latency1", 64'(cyc), 64'(e1.due));
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; start is sampled on the next edge.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic s, input logic [7:0] es, input logic eco, input logic eov);
    exp_t e;
    a8 = a; b8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
    e.s = es; e.co = eco; e.ov = eov; e.due = cyc + 1 + 8;
    q8.push_back(e);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic s, input logic [7:0] es, input logic eco, input logic eov);
    launch8(a, b, c, s, es, eco, eov);
    wait_cycles(1);
    start8 = 1'b0;
    wait_cycles(9);
  endtask

  task automatic op1(input logic a, input logic b, input logic c);
    exp_t e;
    a1 = a; b1 = b; cin1 = c; sub1 = 1'b0; start1 = 1'b1;
    e.s  = {7'd0, a ^ b ^ c};
    e.co = (a & b) | (c & (a ^ b));
    e.ov = c ^ e.co;
    e.due = cyc + 1 + 1;
    q1.push_back(e);
    wait_cycles(1);
    start1 = 1'b0;
    wait_cycles(2);
  endtask

  logic [7:0] bb_a [3];
  logic [7:0] bb_b [3];
  logic       bb_c [3];
  logic [7:0] bb_s [3];
  logic       bb_co[3];
  logic       bb_ov[3];

  initial begin
    n_tests = 0; n_fail = 0;
    start8 = 0; sub8 = 0; cin8 = 0; a8 = '0; b8 = '0;
    start1 = 0; sub1 = 0; cin1 = 0; a1 = '0; b1 = '0;
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(1);

    chk("rst_busy", {63'd0, busy8}, 64'd0);
    chk("rst_done", {63'd0, done8}, 64'd0);
    chk("rst_sum", {56'd0, sum8}, 64'd0);
    chk("rst_cout", {63'd0, cout8}, 64'd0);
    chk("rst_ovf", {63'd0, ovf8}, 64'd0);

    // Zero add with busy-window check
    launch8(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    wait_cycles(1);
    start8 = 1'b0;
    chk("busy_on", {63'd0, busy8}, 64'd1);
    for (int i = 0; i < 7; i++) begin
      wait_cycles(1);
      chk("busy_on", {63'd0, busy8}, 64'd1);
    end
    wait_cycles(1);
    chk("busy_off_in_done", {63'd0, busy8}, 64'd0);
    wait_cycles(1);

    op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    op8(8'h64, 8'h1E, 1'b1, 1'b0, 8'h83, 1'b0, 1'b1);

    // Back-to-back with start held high and garbage operands while busy
    bb_a[0] = 8'h12; bb_b[0] = 8'h34; bb_c[0] = 1'b0; bb_s[0] = 8'h46; bb_co[0] = 1'b0; bb_ov[0] = 1'b0;
    bb_a[1] = 8'hF0; bb_b[1] = 8'h0F; bb_c[1] = 1'b1; bb_s[1] = 8'h00; bb_co[1] = 1'b1; bb_ov[1] = 1'b0;
    bb_a[2] = 8'h40; bb_b[2] = 8'h40; bb_c[2] = 1'b0; bb_s[2] = 8'h80; bb_co[2] = 1'b0; bb_ov[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      launch8(bb_a[i], bb_b[i], bb_c[i], 1'b0, bb_s[i], bb_co[i], bb_ov[i]);
      wait_cycles(1);
      a8 = 8'hA5; b8 = 8'h5A; sub8 = 1'b1; cin8 = 1'b1;
      wait_cycles(3);
      start8 = 1'b0;
      wait_cycles(1);
      start8 = 1'b1;
      wait_cycles(4);
    end
    start8 = 1'b0;
    sub8 = 1'b0;
    wait_cycles(2);

    // Asynchronous reset mid-operation
    launch8(8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    wait_cycles(1);
    start8 = 1'b0;
    wait_cycles(3);
    #2 rst = 1'b1;
    #1;
    q8.delete();
    chk("abort_sum", {56'd0, sum8}, 64'd0);
    chk("abort_busy", {63'd0, busy8}, 64'd0);
    chk("abort_done", {63'd0, done8}, 64'd0);
    chk("abort_cout", {63'd0, cout8}, 64'd0);
    chk("abort_ovf", {63'd0, ovf8}, 64'd0);
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(12);
    op8(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);

    // WIDTH=1 full-adder truth table
    for (int i = 0; i < 8; i++) begin
      op1(i[2], i[1], i[0]);
    end

    wait_cycles(5);
    chk("pending8", 64'(q8.size()), 64'd0);
    chk("pending1", 64'(q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial add/subtract controller that time-multiplexes one one-bit full-adder cell over a WIDTH-bit operation.
- Latches two operands on start and feeds one bit pair per clock through the cell, LSB first.
- Holds the carry in a flip-flop between bits and shifts the result into a sum register.
- Sits between a requesting datapath and the shared adder cell; presents a start/busy/done handshake.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 1..32)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when accepted (see Behaviour)
sub  input  1  0 = a+b+cin, 1 = a-b (b inverted, carry-in forced 1, cin ignored)
a  input  WIDTH  operand A, sampled with accepted start
b  input  WIDTH  operand B, sampled with accepted start
cin  input  1  carry-in for add, sampled with accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when result valid
sum  output  WIDTH  result; stable from done until next accepted start
cout  output  1  final carry out (for subtract: 1 = no borrow)
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, done, sum, cout, overflow, carry FF, counter, operand shift regs all 0.
- States: IDLE, SHIFT, DONE.
- Start acceptance:
  - start is accepted in IDLE or DONE.
  - On acceptance: a_sr<=a; b_sr<=sub ? ~b : b; carry<=sub ? 1 : cin; cnt<=0; go to SHIFT.
- SHIFT, every cycle:
  - Cell inputs are a_sr[0], b_sr[0], carry.
  - carry<=cell cout.
  - sum<={cell s, sum[WIDTH-1:1]}.
  - a_sr and b_sr shift right by 1.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1: capture carry-in of the MSB (the current carry) for overflow, cout<=cell cout, go to DONE.
- DONE: done=1 for exactly this one cycle. Next state is SHIFT if start is high this cycle, else IDLE.
- Latency: start sampled at edge N; done is high in the cycle following edge N+WIDTH. Back-to-back throughput is one result every WIDTH+1 cycles.
- busy = (state==SHIFT). done = (state==DONE). Both are registered-state decodes with no combinational path from inputs.
- start while busy: ignored. No queuing; operands are not resampled.
- sum, cout and overflow:
  - Update only during SHIFT and at its last bit.
  - Hold their values through DONE and IDLE.
  - sum shows partial/shifting bits while busy, so consumers must qualify with done.
- Width rules: all arithmetic is mod 2^WIDTH. For WIDTH=1, SHIFT lasts one cycle.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No done pulse is produced for the aborted operation.
- Inputs a, b, cin and sub may change freely while busy without effect.

Decomposition:
- Shared package serial_adder_pkg: state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and a MAX_WIDTH=32 constant.
- One sub-module: the team's existing one-bit full-adder cell (SingleStage).
  - Instantiated exactly once.
  - Carry FF, shift registers, counter and FSM stay in serial_adder_ctrl.

Test Plan:
- WIDTH=8, a=0x00, b=0x00, cin=0, sub=0, start 1 cycle -> busy high 8 cycles, done pulse 9 cycles after start sample; sum=0x00, cout=0, overflow=0.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, overflow=1.
- WIDTH=8, sub=1, a=0x05, b=0x07, cin=1 (ignored) -> sum=0xFE, cout=0, overflow=0. Then a=0x80, b=0x01 -> sum=0x7F, cout=1, overflow=1.
- WIDTH=8, start held high continuously with a new operand pair each accept -> results every 9 cycles.
  - Pulses of start during busy with different a/b are ignored.
  - The start seen in the DONE cycle launches the next operation with no IDLE gap.
- WIDTH=8, rst asserted asynchronously mid-cycle after 4 SHIFT cycles of a=0xAA, b=0x55 -> outputs 0 immediately, no done pulse.
  - The next start with a=0x03, b=0x04 gives sum=0x07.
- WIDTH=1, all 8 combinations of a, b, cin -> sum/cout match the full-adder truth table, each done 2 cycles after start.
